// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI serial-SRAM responder: opcodes, FSM states
// and the wire address length.
package spi_ram_pkg;

  localparam logic [7:0] OP_READ   = 8'h03;
  localparam logic [7:0] OP_WRITE  = 8'h02;
  localparam int         ADDR_BITS = 16;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    READ,
    WRITE,
    IGNORE
  } state_e;

endpackage

// File: rtl/spi_ram_responder_if.sv
// SPI pin bundle between a master and the serial-SRAM responder.
interface spi_ram_responder_if;

  logic cs_n;
  logic sck;
  logic mosi;
  logic miso;
  logic miso_oe;

  modport master (output cs_n, output sck, output mosi, input miso, input miso_oe);
  modport slave  (input cs_n, input sck, input mosi, output miso, output miso_oe);

endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous level, with one-clock rise and
// fall pulses derived from the synchronized value.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync;
  logic              prev;

  // Reset to the line's idle level so releasing reset never fakes an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= {STAGES{RST_VAL}};
      prev <= RST_VAL;
    end else begin
      sync <= {sync[STAGES-2:0], din};
      prev <= sync[STAGES-1];
    end
  end

  assign level = sync[STAGES-1];
  assign rise  =  level & ~prev;
  assign fall  = ~level &  prev;

endmodule

// File: rtl/spi_ram_responder.sv
// SPI mode-0 slave that emulates a 23LC512-style serial SRAM (READ/WRITE,
// sequential addressing) on top of a 2**ADDR_W byte array, all in clk domain.
module spi_ram_responder
  import spi_ram_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  spi_ram_responder_if.slave   spi,
  output logic                 busy,
  output logic                 cmd_err,
  output logic                 wr_en,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic [7:0]           wr_data
);

  logic cs_level, cs_rise, cs_fall;
  logic sck_unused, sck_rise, sck_fall;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic mosi_s;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clk(clk), .rst(rst), .din(spi.cs_n),
    .level(cs_level), .rise(cs_rise), .fall(cs_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck_sync (
    .clk(clk), .rst(rst), .din(spi.sck),
    .level(sck_unused), .rise(sck_rise), .fall(sck_fall)
  );

  always_ff @(posedge clk) begin
    if (rst) mosi_sync <= '0;
    else     mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi.mosi};
  end
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  state_e                 state, state_n;
  logic [3:0]             bit_cnt, bit_cnt_n;
  logic [ADDR_BITS-2:0]   sh, sh_n;       // last bit of any field comes straight from mosi_s
  logic [ADDR_W-1:0]      addr, addr_n;
  logic                   is_read, is_read_n;
  logic [7:0]             out_sh, out_sh_n;
  logic                   oe, oe_n;
  logic                   cmd_err_n, wr_en_n, mem_we;
  logic [ADDR_W-1:0]      wr_addr_n;
  logic [7:0]             wr_data_n, byte_in;
  logic [7:0]             mem [0:2**ADDR_W-1];

  assign byte_in = {sh[6:0], mosi_s};

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      sh      <= '0;
      addr    <= '0;
      is_read <= 1'b0;
      out_sh  <= '0;
      oe      <= 1'b0;
      cmd_err <= 1'b0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_cnt_n;
      sh      <= sh_n;
      addr    <= addr_n;
      is_read <= is_read_n;
      out_sh  <= out_sh_n;
      oe      <= oe_n;
      cmd_err <= cmd_err_n;
      wr_en   <= wr_en_n;
      wr_addr <= wr_addr_n;
      wr_data <= wr_data_n;
    end
  end

  // NOTE: every variable gets a default before the case so no path infers a latch;
  // combinational blocks use blocking '=', clocked blocks only '<='.
  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    sh_n      = sh;
    addr_n    = addr;
    is_read_n = is_read;
    out_sh_n  = out_sh;
    oe_n      = oe;
    cmd_err_n = 1'b0;
    wr_en_n   = 1'b0;
    wr_addr_n = wr_addr;
    wr_data_n = wr_data;
    mem_we    = 1'b0;

    // Deselect wins over a coincident sck edge; a partial byte is dropped.
    if (state != IDLE && cs_rise) begin
      state_n   = IDLE;
      bit_cnt_n = '0;
      sh_n      = '0;
      out_sh_n  = '0;
      oe_n      = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cs_fall) begin
            state_n   = CMD;
            bit_cnt_n = '0;
            sh_n      = '0;
          end
        end

        CMD: begin
          if (sck_rise) begin
            sh_n      = {sh[ADDR_BITS-3:0], mosi_s};
            bit_cnt_n = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              bit_cnt_n = '0;
              sh_n      = '0;
              if (byte_in == OP_READ || byte_in == OP_WRITE) begin
                state_n   = ADDR;
                is_read_n = (byte_in == OP_READ);
              end else begin
                state_n   = IGNORE;
                cmd_err_n = 1'b1;
              end
            end
          end
        end

        ADDR: begin
          if (sck_rise) begin
            sh_n      = {sh[ADDR_BITS-3:0], mosi_s};
            bit_cnt_n = bit_cnt + 4'd1;
            if (bit_cnt == 4'd15) begin
              bit_cnt_n = '0;
              sh_n      = '0;
              addr_n    = ADDR_W'({sh, mosi_s});
              if (is_read) begin
                state_n  = READ;
                out_sh_n = mem[addr_n];
                oe_n     = 1'b1;
              end else begin
                state_n = WRITE;
              end
            end
          end
        end

        // bit_cnt counts bits the master has sampled; the fall right after the
        // last address bit must leave the first data bit in place.
        READ: begin
          if (sck_rise) begin
            bit_cnt_n = bit_cnt + 4'd1;
          end else if (sck_fall) begin
            if (bit_cnt == 4'd8) begin
              bit_cnt_n = '0;
              addr_n    = addr + 1'b1;
              out_sh_n  = mem[addr_n];
            end else if (bit_cnt != 4'd0) begin
              out_sh_n = {out_sh[6:0], 1'b0};
            end
          end
        end

        WRITE: begin
          if (sck_rise) begin
            sh_n      = {sh[ADDR_BITS-3:0], mosi_s};
            bit_cnt_n = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              bit_cnt_n = '0;
              sh_n      = '0;
              mem_we    = 1'b1;
              wr_en_n   = 1'b1;
              wr_addr_n = addr;
              wr_data_n = byte_in;
              addr_n    = addr + 1'b1;
            end
          end
        end

        IGNORE: ;

        default: state_n = IDLE;
      endcase
    end
  end

  // NOTE: the array has no reset; its contents must survive rst.
  always_ff @(posedge clk) begin
    if (mem_we) mem[addr] <= byte_in;
  end

  assign spi.miso    = out_sh[7];
  assign spi.miso_oe = oe;
  assign busy        = ~cs_level;

endmodule

// File: tb/tb_spi_ram_responder.sv
// Directed bench for spi_ram_responder: a mode-0 SPI master drives
// WRITE/READ/unknown/abort/reset scenarios and checks hand-computed results.
module tb_spi_ram_responder;
  import spi_ram_pkg::*;

  localparam int ADDR_W      = 8;
  localparam int SYNC_STAGES = 2;
  localparam int HALF        = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic              busy, cmd_err, wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;

  spi_ram_responder_if spi_bus ();

  spi_ram_responder #(.ADDR_W(ADDR_W), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .rst(rst), .spi(spi_bus.slave),
    .busy(busy), .cmd_err(cmd_err), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_cmd_err = 0;
  logic [15:0] wr_q[$];

  always @(negedge clk) begin
    if (wr_en)   wr_q.push_back({wr_addr, wr_data});
    if (cmd_err) n_cmd_err++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [15:0] wr_at(input int i);
    return (wr_q.size() > i) ? wr_q[i] : 16'hFFFF;
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Shift nbits of tx (MSB first); capture miso and miso_oe just before each rise.
  task automatic xfer(input logic [7:0] tx, input int nbits,
                      output logic [7:0] rx, output logic [7:0] oe);
    rx = '0;
    oe = '0;
    for (int i = 7; i >= 8 - nbits; i--) begin
      spi_bus.mosi = tx[i];
      wait_clk(HALF);
      rx[i] = spi_bus.miso;
      oe[i] = spi_bus.miso_oe;
      spi_bus.sck = 1'b1;
      wait_clk(HALF);
      spi_bus.sck = 1'b0;
    end
  endtask

  task automatic cs_low();
    spi_bus.cs_n = 1'b0;
  endtask

  task automatic cs_high();
    wait_clk(HALF);
    spi_bus.cs_n = 1'b1;
    wait_clk(2 * HALF);
  endtask

  task automatic send_hdr(input logic [7:0] op, input logic [15:0] a, output logic [7:0] hdr_oe);
    logic [7:0] rx, oe;
    hdr_oe = '0;
    xfer(op, 8, rx, oe);      hdr_oe |= oe;
    xfer(a[15:8], 8, rx, oe); hdr_oe |= oe;
    xfer(a[7:0], 8, rx, oe);  hdr_oe |= oe;
  endtask

  task automatic write_seq(input logic [15:0] a, input logic [23:0] data, input int n);
    logic [7:0] rx, oe, hoe;
    cs_low();
    send_hdr(OP_WRITE, a, hoe);
    for (int i = 0; i < n; i++) xfer(data[23-8*i -: 8], 8, rx, oe);
    cs_high();
  endtask

  task automatic read_seq(input logic [15:0] a, input int n, output logic [23:0] data,
                          output logic [7:0] hdr_oe, output logic [7:0] data_oe);
    logic [7:0] rx, oe;
    data    = '0;
    data_oe = 8'hFF;
    cs_low();
    send_hdr(OP_READ, a, hdr_oe);
    for (int i = 0; i < n; i++) begin
      xfer(8'h00, 8, rx, oe);
      data[23-8*i -: 8] = rx;
      data_oe &= oe;
    end
    cs_high();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " miso"},    spi_bus.miso, 0);
    check({tag, " miso_oe"}, spi_bus.miso_oe, 0);
    check({tag, " busy"},    busy, 0);
    check({tag, " cmd_err"}, cmd_err, 0);
    check({tag, " wr_en"},   wr_en, 0);
    check({tag, " wr_addr"}, wr_addr, 0);
    check({tag, " wr_data"}, wr_data, 0);
  endtask

  initial begin
    logic [23:0] rd;
    logic [7:0]  hoe, doe, rx, oe;
    int          err_base;

    rst = 1'b1;
    spi_bus.cs_n = 1'b1;
    spi_bus.sck  = 1'b0;
    spi_bus.mosi = 1'b0;
    wait_clk(4);
    check_reset_outputs("reset");
    rst = 1'b0;
    wait_clk(4);

    // Write then read back
    wr_q.delete();
    write_seq(16'h0010, 24'hA5_0000, 1);
    check("wr1 count", wr_q.size(), 1);
    check("wr1 event", wr_at(0), 16'h10A5);
    check("wr1 busy after", busy, 0);
    read_seq(16'h0010, 1, rd, hoe, doe);
    check("rd1 data", rd[23:16], 8'hA5);
    check("rd1 hdr oe", hoe, 8'h00);
    check("rd1 data oe", doe, 8'hFF);
    check("rd1 oe after", spi_bus.miso_oe, 0);
    check("rd1 miso after", spi_bus.miso, 0);

    // Sequential write with address wrap; upper address bits ignored
    wr_q.delete();
    write_seq(16'h00FF, 24'h1122_00, 2);
    check("wrap count", wr_q.size(), 2);
    check("wrap ev0", wr_at(0), 16'hFF11);
    check("wrap ev1", wr_at(1), 16'h0022);
    wr_q.delete();
    write_seq(16'h12FF, 24'h3344_00, 2);
    check("wrap hi count", wr_q.size(), 2);
    check("wrap hi ev0", wr_at(0), 16'hFF33);
    check("wrap hi ev1", wr_at(1), 16'h0044);

    // Sequential read, including read wrap from 0xFF to 0x00
    write_seq(16'h0040, 24'hDEADBE, 3);
    read_seq(16'h0040, 3, rd, hoe, doe);
    check("seq rd data", rd, 24'hDEADBE);
    check("seq rd oe", doe, 8'hFF);
    read_seq(16'h12FF, 2, rd, hoe, doe);
    check("rd wrap data", rd[23:8], 16'h3344);

    // Unknown opcode
    wr_q.delete();
    err_base = n_cmd_err;
    cs_low();
    send_hdr(8'h9F, 16'h0000, hoe);
    xfer(8'h00, 8, rx, oe);
    hoe |= oe;
    cs_high();
    check("bad op cmd_err", n_cmd_err - err_base, 1);
    check("bad op oe", hoe, 8'h00);
    check("bad op wr_en", wr_q.size(), 0);

    // Abort mid-byte
    write_seq(16'h0020, 24'h5A_0000, 1);
    wr_q.delete();
    cs_low();
    send_hdr(OP_WRITE, 16'h0020, hoe);
    xfer(8'hF0, 4, rx, oe);
    check("abort busy during", busy, 1);
    cs_high();
    check("abort wr_en", wr_q.size(), 0);
    check("abort busy after", busy, 0);
    read_seq(16'h0020, 1, rd, hoe, doe);
    check("abort mem kept", rd[23:16], 8'h5A);

    // Reset mid-read
    cs_low();
    send_hdr(OP_READ, 16'h0010, hoe);
    xfer(8'h00, 3, rx, oe);
    check("pre-rst bits", rx[7:5], 3'b101);
    rst = 1'b1;
    wait_clk(1);
    check_reset_outputs("mid rst");
    wait_clk(2);
    rst = 1'b0;
    spi_bus.cs_n = 1'b1;
    wait_clk(2 * HALF);
    read_seq(16'h0010, 1, rd, hoe, doe);
    check("post-rst 0x10", rd[23:16], 8'hA5);
    read_seq(16'h0040, 3, rd, hoe, doe);
    check("post-rst 0x40", rd, 24'hDEADBE);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
